// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit path.
//   - uart_state_e : serializer FSM state encoding
//   - PARITY_*     : PARITY_MODE selector values
//   - CLKS_PER_BIT_DEFAULT : 115200 baud from a 50 MHz clock
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/parity_generator.sv
// parity_generator: combinational even-parity bit of one byte.
//   data_i       [7:0] in  : byte to protect
//   parity_bit_o       out : XOR of all bits of data_i (even parity)
module parity_generator (
  input  logic [7:0] data_i,
  output logic       parity_bit_o
);

  assign parity_bit_o = ^data_i;

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit framing stage. Accepts one byte per
// valid/ready handshake and shifts out start, 8 data bits (LSB first),
// optional parity and 1 or 2 stop bits, each held CLKS_PER_BIT cycles.
//   clk            in  : system clock, rising edge
//   rst            in  : synchronous active-high reset
//   tx_data  [7:0] in  : byte to send, sampled on handshake only
//   tx_valid       in  : source offers tx_data
//   tx_ready       out : serializer idle and able to accept a byte
//   tx             out : serial line, idles high, registered
//   busy           out : frame in progress (handshake edge to last stop)
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int PARITY_MODE  = PARITY_EVEN,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // Unsupported parity / stop settings fall back to none / one stop bit.
  localparam bit HAS_PARITY = (PARITY_MODE == PARITY_EVEN) || (PARITY_MODE == PARITY_ODD);
  localparam bit ODD_PARITY = (PARITY_MODE == PARITY_ODD);
  localparam bit TWO_STOP   = (STOP_BITS == 2);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             gen_parity;
  logic             bit_end;

  // The shift register is untouched during START, so it still holds the
  // accepted byte when the parity bit is captured there.
  parity_generator u_parity (
    .data_i       (shift_q),
    .parity_bit_o (gen_parity)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state, counters and next output levels.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = 1'b1;

    case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          state_d   = START;
          shift_d   = tx_data;
          bit_idx_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        parity_d = gen_parity ^ ODD_PARITY;
        if (bit_end) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d   = HAS_PARITY ? PARITY : STOP;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (bit_end) begin
          // bit_idx counts completed stop periods when two are configured.
          if (TWO_STOP && (bit_idx_q == 3'd0)) begin
            bit_idx_d = 3'd1;
          end else begin
            state_d   = IDLE;
            bit_idx_d = 3'd0;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_idx_d = 3'd0;
      end
    endcase

    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs are decoded from the next state so tx changes exactly on the
    // bit boundary edge, straight out of a flop.
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: four serializers (even/1 stop, odd/1 stop,
// no parity/1 stop, even/2 stop) at CLKS_PER_BIT=4. Expected per-cycle
// {tx,busy,tx_ready} values are queued from a frame model when a byte is
// sent and compared at every falling edge.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [3:0] valid_r;
  logic [7:0] data_r [4];
  wire  [3:0] tx_w;
  wire  [3:0] busy_w;
  wire  [3:0] ready_w;

  int pm_cfg [4] = '{1, 2, 0, 1};
  int sb_cfg [4] = '{1, 1, 1, 2};

  typedef logic [2:0] obs_t; // {tx, busy, tx_ready}
  obs_t exp_q[$];

  int n_checks;
  int n_fail;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) dut_even (
    .clk(clk), .rst(rst), .tx_data(data_r[0]), .tx_valid(valid_r[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1)) dut_odd (
    .clk(clk), .rst(rst), .tx_data(data_r[1]), .tx_valid(valid_r[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) dut_none (
    .clk(clk), .rst(rst), .tx_data(data_r[2]), .tx_valid(valid_r[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(2)) dut_two (
    .clk(clk), .rst(rst), .tx_data(data_r[3]), .tx_valid(valid_r[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

  always #5 clk = ~clk;

  task automatic push_bit(input logic b);
    for (int c = 0; c < CPB; c++) exp_q.push_back({b, 1'b1, 1'b0});
  endtask

  task automatic push_idle();
    exp_q.push_back(3'b101);
  endtask

  // Frame model: start, data LSB first, optional parity, stop bit(s).
  task automatic push_frame(input int idx, input logic [7:0] d);
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) push_bit(d[i]);
    if (pm_cfg[idx] == 1) push_bit(^d);
    if (pm_cfg[idx] == 2) push_bit(~(^d));
    push_bit(1'b1);
    if (sb_cfg[idx] == 2) push_bit(1'b1);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic accept(input int idx, input logic [7:0] d, input bit keep);
    n_checks++;
    if (ready_w[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready dut%0d: tx_ready got %b expected 1", idx, ready_w[idx]);
    end
    data_r[idx]  = d;
    valid_r[idx] = 1'b1;
    @(negedge clk);
    if (!keep) valid_r[idx] = 1'b0;
  endtask

  task automatic check_stream(input int idx, input string name, input int drop_k, input int pulse_k);
    int   k;
    obs_t got;
    obs_t exp;
    k = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {tx_w[idx], busy_w[idx], ready_w[idx]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s k=%0d {tx,busy,ready} got %b expected %b", name, k, got, exp);
      end
      if (k == drop_k) valid_r[idx] = 1'b0;
      if (pulse_k >= 0 && k == pulse_k) begin
        valid_r[idx] = 1'b1;
        data_r[idx]  = 8'hFF;
      end
      if (pulse_k >= 0 && k == pulse_k + 1) valid_r[idx] = 1'b0;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({tx_w[i], busy_w[i], ready_w[i]} !== 3'b101) begin
        n_fail++;
        $display("FAIL reset dut%0d {tx,busy,ready} got %b expected 101", i, {tx_w[i], busy_w[i], ready_w[i]});
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if ({tx_w[i], busy_w[i], ready_w[i]} !== 3'b101) begin
          n_fail++;
          $display("FAIL idle c=%0d dut%0d got %b expected 101", c, i, {tx_w[i], busy_w[i], ready_w[i]});
        end
      end
    end
  endtask

  task automatic test_even_parity();
    accept(0, 8'h55, 1'b0);
    push_frame(0, 8'h55);   // 44 cycles, then idle with busy low
    push_idle();
    check_stream(0, "even_55", -1, -1);
  endtask

  task automatic test_odd_and_none();
    accept(1, 8'h07, 1'b0);
    push_frame(1, 8'h07);
    push_idle();
    check_stream(1, "odd_07", -1, -1);
    accept(2, 8'h07, 1'b0);
    push_frame(2, 8'h07);   // 40 cycles
    push_idle();
    check_stream(2, "none_07", -1, -1);
  endtask

  task automatic test_back_to_back();
    accept(3, 8'hA5, 1'b1);
    data_r[3] = 8'h3C;      // held on tx_valid for the next frame
    push_frame(3, 8'hA5);   // 48 cycles
    push_idle();            // the single tx_ready cycle
    push_frame(3, 8'h3C);
    push_idle();
    check_stream(3, "b2b", 49, -1);
  endtask

  task automatic test_handshake();
    accept(0, 8'h96, 1'b0);
    data_r[0] = 8'h00;      // must not affect the frame in flight
    push_frame(0, 8'h96);
    repeat (4) push_idle();
    check_stream(0, "handshake", -1, 10);
  endtask

  task automatic test_reset_mid_frame();
    obs_t got;
    obs_t exp;
    accept(0, 8'hC3, 1'b0);
    push_frame(0, 8'hC3);
    for (int k = 0; k < 18; k++) begin
      exp = exp_q.pop_front();
      got = {tx_w[0], busy_w[0], ready_w[0]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL midrst_pre k=%0d got %b expected %b", k, got, exp);
      end
      if (k < 17) @(negedge clk);
    end
    rst = 1'b1;             // during data bit 3 (cycles 16..19)
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if ({tx_w[0], busy_w[0], ready_w[0]} !== 3'b101) begin
        n_fail++;
        $display("FAIL midrst_idle c=%0d got %b expected 101", c, {tx_w[0], busy_w[0], ready_w[0]});
      end
      if (c == 0) @(negedge clk);
    end
    accept(0, 8'hFF, 1'b0);
    push_frame(0, 8'hFF);
    push_idle();
    check_stream(0, "after_rst_FF", -1, -1);
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    valid_r  = 4'b0000;
    for (int i = 0; i < 4; i++) data_r[i] = 8'h00;
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_even_parity();
    test_odd_and_none();
    test_back_to_back();
    test_handshake();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
